// File: rtl/udt_ctrl_pkg.sv
// Shared control-packet definitions: control types, arbiter state encoding,
// beat geometry and the control-header builder.
package udt_ctrl_pkg;

   localparam int unsigned BEAT_W = 64;
   localparam int unsigned KEEP_W = BEAT_W / 8;

   localparam logic [14:0] CTRL_KEEPALIVE = 15'h0001;
   localparam logic [14:0] CTRL_ACK       = 15'h0002;
   localparam logic [14:0] CTRL_NAK       = 15'h0003;
   localparam logic [14:0] CTRL_SHUTDOWN  = 15'h0005;
   localparam logic [14:0] CTRL_ACK2      = 15'h0006;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_KA0,
      ST_KA1
   } arb_state_e;

   // First beat of a control packet: control flag, type, reserved, additional info.
   function automatic logic [BEAT_W-1:0] ctrl_hdr(input logic [14:0] ctype);
      return {1'b1, ctype, 16'h0000, 32'h0000_0000};
   endfunction

endpackage

// File: rtl/ctrl_arb_pick.sv
// Combinational winner select: first requester found scanning upward from ptr
// (ptr tied to zero gives fixed lowest-index priority).
module ctrl_arb_pick
   import udt_ctrl_pkg::*;
#(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               any,
   output logic [NUM_SRC-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   logic        found;
   int unsigned k;

   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      k      = 0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         k = (32'(ptr) + i) % NUM_SRC;
         if (!found && req[k]) begin
            found     = 1'b1;
            onehot[k] = 1'b1;
            idx       = IDX_W'(k);
         end
      end
      any = |req;
   end

endmodule

// File: rtl/ctrl_pkt_arbiter.sv
// Packet-locked arbiter for control-packet sources with keep-alive injection
// after a programmable idle period. Define CTRL_ARB_RR_EN for round-robin.
module ctrl_pkt_arbiter
   import udt_ctrl_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 4,
   parameter logic [31:0] KA_CYCLES = 32'd1000000
) (
   input  logic                      core_clk,
   input  logic                      core_rst,
   input  logic [NUM_SRC*BEAT_W-1:0] src_tdata,
   input  logic [NUM_SRC*KEEP_W-1:0] src_tkeep,
   input  logic [NUM_SRC-1:0]        src_tvalid,
   input  logic [NUM_SRC-1:0]        src_tlast,
   output logic [NUM_SRC-1:0]        src_tready,
   output logic [BEAT_W-1:0]         m_tdata,
   output logic [KEEP_W-1:0]         m_tkeep,
   output logic                      m_tvalid,
   output logic                      m_tlast,
   input  logic                      m_tready,
   input  logic                      ka_enable,
   input  logic [31:0]               timestamp,
   input  logic [31:0]               dst_sock_id,
   output logic                      busy
);

   localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [31:0] KA_LIM = KA_CYCLES - 32'd1;

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [NUM_SRC-1:0] grant_oh_q, grant_oh_d;
   logic [31:0]        ka_cnt_q, ka_cnt_d;
   logic               ka_pend_q, ka_pend_d;
   logic [BEAT_W-1:0]  ka_data_q, ka_data_d;

   logic [BEAT_W-1:0]  s_data [NUM_SRC];
   logic [KEEP_W-1:0]  s_keep [NUM_SRC];
   logic               pick_any;
   logic [NUM_SRC-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   pick_ptr;
   logic               m_hs, last_hs;

   ctrl_arb_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
      .req    (src_tvalid),
      .ptr    (pick_ptr),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

`ifdef CTRL_ARB_RR_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == ST_IDLE && pick_any)
         rr_ptr_d = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) rr_ptr_q <= '0;
      else          rr_ptr_q <= rr_ptr_d;
   end

   assign pick_ptr = rr_ptr_q;
`else
   assign pick_ptr = '0;
`endif

   always_comb begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         s_data[i] = src_tdata[BEAT_W*i +: BEAT_W];
         s_keep[i] = src_tkeep[KEEP_W*i +: KEEP_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_oh_d = grant_oh_q;
      ka_data_d  = ka_data_q;
      m_tdata    = '0;
      m_tkeep    = '0;
      m_tvalid   = 1'b0;
      m_tlast    = 1'b0;
      src_tready = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d    = pick_idx;
               grant_oh_d = pick_onehot;
               state_d    = ST_FWD;
            end else if (ka_pend_q) begin
               state_d = ST_KA0;
            end
         end
         ST_FWD: begin
            m_tdata    = s_data[grant_q];
            m_tkeep    = s_keep[grant_q];
            m_tvalid   = src_tvalid[grant_q];
            m_tlast    = src_tlast[grant_q];
            src_tready = grant_oh_q & {NUM_SRC{m_tready}};
            if (m_tvalid && m_tready && m_tlast) state_d = ST_IDLE;
         end
         ST_KA0: begin
            m_tdata  = ctrl_hdr(CTRL_KEEPALIVE);
            m_tkeep  = '1;
            m_tvalid = 1'b1;
            if (m_tready) begin
               ka_data_d = {timestamp, dst_sock_id};
               state_d   = ST_KA1;
            end
         end
         ST_KA1: begin
            m_tdata  = ka_data_q;
            m_tkeep  = '1;
            m_tvalid = 1'b1;
            m_tlast  = 1'b1;
            if (m_tready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshakes are blocked for the whole reset cycle so an interrupted packet emits nothing more.
      if (core_rst) begin
         m_tvalid   = 1'b0;
         src_tready = '0;
      end
      busy = (state_q != ST_IDLE) && !core_rst;
   end

   always_comb begin
      m_hs      = m_tvalid & m_tready;
      last_hs   = m_hs & m_tlast;
      ka_cnt_d  = ka_cnt_q;
      ka_pend_d = ka_pend_q;
      if (!ka_enable || last_hs)
         ka_cnt_d = '0;
      else if (!m_hs && ka_cnt_q != KA_LIM)
         ka_cnt_d = ka_cnt_q + 32'd1;
      if (last_hs)
         ka_pend_d = 1'b0;
      else if (ka_cnt_q == KA_LIM)
         ka_pend_d = 1'b1;
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         ka_cnt_q   <= '0;
         ka_pend_q  <= 1'b0;
         ka_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_oh_q <= grant_oh_d;
         ka_cnt_q   <= ka_cnt_d;
         ka_pend_q  <= ka_pend_d;
         ka_data_q  <= ka_data_d;
      end
   end

endmodule

// File: tb/tb_ctrl_pkt_arbiter.sv
// Self-checking bench for ctrl_pkt_arbiter: vector table plus directed
// multi-cycle sequences, with an output scoreboard queue.
module tb_ctrl_pkt_arbiter;

   localparam int unsigned NS = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NS*64-1:0] src_tdata;
   logic [NS*8-1:0]  src_tkeep;
   logic [NS-1:0]    src_tvalid, src_tlast, src_tready;
   logic [63:0]      m_tdata;
   logic [7:0]       m_tkeep;
   logic             m_tvalid, m_tlast, m_tready;
   logic             ka_enable, busy;
   logic [31:0]      timestamp, dst_sock_id;

   always #5 clk = ~clk;

   ctrl_pkt_arbiter #(.NUM_SRC(NS), .KA_CYCLES(32'd16)) dut (
      .core_clk    (clk),
      .core_rst    (rst),
      .src_tdata   (src_tdata),
      .src_tkeep   (src_tkeep),
      .src_tvalid  (src_tvalid),
      .src_tlast   (src_tlast),
      .src_tready  (src_tready),
      .m_tdata     (m_tdata),
      .m_tkeep     (m_tkeep),
      .m_tvalid    (m_tvalid),
      .m_tlast     (m_tlast),
      .m_tready    (m_tready),
      .ka_enable   (ka_enable),
      .timestamp   (timestamp),
      .dst_sock_id (dst_sock_id),
      .busy        (busy)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   typedef struct packed {
      logic [3:0] mask;
      logic [7:0] keep;
      logic [7:0] exp_first;
      logic [7:0] exp_beats;
   } vec_t;

   beat_t srcq [NS][$];
   beat_t exp_q[$];
   vec_t  tbl [4];

   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          out_cnt = 0;
   int          out_cyc[$];
   int          rdy_mode = 0;
   logic [7:0]  first_src;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic        prev_last;
   logic [NS-1:0] acc;

   function automatic beat_t mk(input int s, input int b, input int tag,
                                input logic [7:0] keep, input logic last);
      beat_t r;
      r.data = {8'(s), 8'(b), 16'(tag), 32'hC0DE_0000 | 32'(tag * 16 + b)};
      r.keep = keep;
      r.last = last;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic drive_srcs();
      for (int i = 0; i < NS; i++) begin
         if (srcq[i].size() > 0) begin
            src_tvalid[i]       = 1'b1;
            src_tdata[64*i +: 64] = srcq[i][0].data;
            src_tkeep[8*i +: 8]   = srcq[i][0].keep;
            src_tlast[i]        = srcq[i][0].last;
         end else begin
            src_tvalid[i]       = 1'b0;
            src_tdata[64*i +: 64] = '0;
            src_tkeep[8*i +: 8]   = '0;
            src_tlast[i]        = 1'b0;
         end
      end
   endtask

   task automatic tick();
      beat_t e;
      @(negedge clk);
      cyc++;
      if (prev_stall && !rst) begin
         vectors++;
         if (!(m_tvalid === 1'b1 && m_tdata === prev_data && m_tlast === prev_last)) begin
            miscompares++;
            $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
         end
      end
      prev_stall = m_tvalid && !m_tready && !rst;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (m_tvalid && m_tready) begin
         vectors++;
         out_cnt++;
         out_cyc.push_back(cyc);
         if (out_cnt == 1) first_src = m_tdata[63:56];
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL out_beat: unexpected beat data=%h last=%b, required no beat", m_tdata, m_tlast);
         end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
               miscompares++;
               $display("FAIL out_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                        m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
            end
         end
      end
      acc = src_tvalid & src_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
         if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      drive_srcs();
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'b0;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_src_tready", 64'(src_tready), 64'd0);
      for (int i = 0; i < NS; i++) srcq[i].delete();
      exp_q.delete();
      rdy_mode = 2;
      m_tready = 1'b0;
      drive_srcs();
      tick();
      rst = 1'b0;
      #1;
      chk("post_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      chk("post_rst_src_tready", 64'(src_tready), 64'd0);
      out_cnt = 0;
      out_cyc.delete();
      prev_stall = 1'b0;
      rdy_mode = 0;
      m_tready = 1'b1;
   endtask

   task automatic load_pkt(input int s, input int n, input int tag,
                           input logic [7:0] keep, input bit push_exp);
      beat_t bt;
      for (int b = 0; b < n; b++) begin
         bt = mk(s, b, tag, keep, (b == n - 1));
         srcq[s].push_back(bt);
         if (push_exp) exp_q.push_back(bt);
      end
      drive_srcs();
   endtask

   task automatic drain(input int budget, input string nm);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timeout with %0d beats outstanding, required 0", nm, exp_q.size());
      end
   endtask

   initial begin
      int lat, gap;
      ka_enable   = 1'b0;
      timestamp   = '0;
      dst_sock_id = '0;
      m_tready    = 1'b0;
      drive_srcs();
      repeat (2) @(posedge clk);
      #1;

      tbl[0] = '{mask: 4'b0001, keep: 8'hFF, exp_first: 8'd0, exp_beats: 8'd1};
      tbl[1] = '{mask: 4'b0110, keep: 8'h0F, exp_first: 8'd1, exp_beats: 8'd2};
      tbl[2] = '{mask: 4'b1000, keep: 8'h01, exp_first: 8'd3, exp_beats: 8'd1};
      tbl[3] = '{mask: 4'b1111, keep: 8'hF0, exp_first: 8'd0, exp_beats: 8'd4};

      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int s = 0; s < NS; s++)
            if (tbl[r].mask[s]) load_pkt(s, 1, r, tbl[r].keep, 1'b1);
         drain(40, "tbl_drain");
         chk("tbl_first_src", 64'(first_src), 64'(tbl[r].exp_first));
         chk("tbl_beats", 64'(out_cnt), 64'(tbl[r].exp_beats));
      end

      // Two sources contend: whole packet from 0, one bubble, then whole packet from 2.
      do_reset();
      load_pkt(0, 3, 10, 8'hFF, 1'b1);
      load_pkt(2, 3, 11, 8'hFF, 1'b1);
      drain(40, "contend_drain");
      gap = (out_cyc.size() >= 4) ? out_cyc[3] - out_cyc[2] : -1;
      chk("bubble_gap", 64'(gap), 64'd2);

      // Downstream stalls every other cycle.
      do_reset();
      rdy_mode = 1;
      m_tready = 1'b1;
      load_pkt(0, 4, 20, 8'h3C, 1'b1);
      drain(40, "stall_drain");
      chk("stall_beats", 64'(out_cnt), 64'd4);

      // Keep-alive after idle period.
      ka_enable   = 1'b1;
      timestamp   = 32'h0000_1234;
      dst_sock_id = 32'hABCD_0001;
      do_reset();
      lat = cyc;
      exp_q.push_back('{data: 64'h8001_0000_0000_0000, keep: 8'hFF, last: 1'b0});
      exp_q.push_back('{data: 64'h0000_1234_ABCD_0001, keep: 8'hFF, last: 1'b1});
      drain(60, "ka_drain");
      lat = (out_cyc.size() > 0) ? out_cyc[0] - lat : -1;
      chk("ka_latency_in_range", 64'(lat >= 17 && lat <= 19), 64'd1);
      ka_enable = 1'b0;

      // Keep-alive becomes pending while a source packet is stalled; it must be dropped.
      ka_enable = 1'b1;
      do_reset();
      rdy_mode = 2;
      m_tready = 1'b0;
      load_pkt(1, 3, 35, 8'hFF, 1'b1);
      repeat (25) tick();
      chk("ka_stall_busy", 64'(busy), 64'd1);
      rdy_mode = 0;
      m_tready = 1'b1;
      drain(20, "ka_src_drain");
      repeat (12) tick();
      chk("no_ka_after_src", 64'(out_cnt), 64'd3);
      ka_enable = 1'b0;

      // All sources continuously valid with one-beat packets.
      do_reset();
      for (int s = 0; s < NS; s++)
         for (int p = 0; p < 5; p++) load_pkt(s, 1, p, 8'hFF, 1'b0);
`ifdef CTRL_ARB_RR_EN
      exp_q.push_back(mk(0, 0, 0, 8'hFF, 1'b1));
      exp_q.push_back(mk(1, 0, 0, 8'hFF, 1'b1));
      exp_q.push_back(mk(2, 0, 0, 8'hFF, 1'b1));
      exp_q.push_back(mk(3, 0, 0, 8'hFF, 1'b1));
      exp_q.push_back(mk(0, 0, 1, 8'hFF, 1'b1));
`else
      for (int p = 0; p < 5; p++) exp_q.push_back(mk(0, 0, p, 8'hFF, 1'b1));
`endif
      drain(40, "order_drain");

      // Reset during the second beat of a four-beat packet.
      do_reset();
      load_pkt(3, 4, 37, 8'hFF, 1'b0);
      exp_q.push_back(mk(3, 0, 37, 8'hFF, 1'b0));
      drain(20, "mid_pkt_drain");
      #1;
      chk("mid_pkt_beat1_valid", 64'(m_tvalid), 64'd1);
      do_reset();
      repeat (3) tick();
      chk("mid_pkt_no_more_beats", 64'(out_cnt), 64'd0);
      load_pkt(2, 2, 38, 8'h0F, 1'b1);
      drain(20, "after_rst_drain");
      chk("after_rst_beats", 64'(out_cnt), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
